// File: rtl/sub_bytes_lp.sv
// sub_bytes_lp: AES SubBytes over a 128-bit block using one shared S-box.
// One byte per cycle; the full result is published in a single update.
module sub_bytes_lp (
  input  logic         clock,
  input  logic         reset,
  input  logic         enableS,
  input  logic [0:127] blocoIn,
  output logic [0:127] blocoOut,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  state_t       stateNext;
  logic [3:0]   idx;
  logic [3:0]   sel;
  logic [0:127] capture;
  logic [0:127] work;
  logic [7:0]   sIn;
  logic [7:0]   sOut;
  logic         start;
  logic         last;

  // Mux parked on byte 0 while idle so the S-box sees no activity.
  assign sel  = (state == RUN) ? idx : 4'd0;
  assign sIn  = capture[{sel, 3'b000} +: 8];
  assign sOut = SBOX[{~sIn, 3'b000} +: 8];
  assign busy = (state == RUN);

  always_comb begin
    stateNext = state;
    start     = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enableS) begin
          start     = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (idx == 4'd15) begin
          last      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= last;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= 4'd0;
    end else if (start) begin
      idx <= 4'd0;
    end else if (state == RUN) begin
      idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      capture <= '0;
    end else if (start) begin
      capture <= blocoIn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work <= '0;
    end else if (state == RUN) begin
      work[{idx, 3'b000} +: 8] <= sOut;
    end
  end

  // Last byte bypasses the work register so the update is one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blocoOut <= '0;
    end else if (last) begin
      blocoOut <= {work[0:119], sOut};
    end
  end

endmodule

// File: tb/tb_sub_bytes_lp.sv
// tb_sub_bytes_lp: directed jobs checked against a GF(2^8) SubBytes model.
// The model tracks the observable job timeline; a compare process checks every cycle.
module tb_sub_bytes_lp;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enableS = 1'b0;
  logic [0:127] blocoIn = '0;
  logic [0:127] blocoOut;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int busyCycles = 0;

  logic [127:0] mOut = '0;
  logic [127:0] mPending = '0;
  logic         mBusy = 1'b0;
  logic         mDone = 1'b0;
  int           mLeft = 0;

  sub_bytes_lp dut (
    .clock(clock),
    .reset(reset),
    .enableS(enableS),
    .blocoIn(blocoIn),
    .blocoOut(blocoOut),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Inverse as x^254, then the AES affine map.
  function automatic logic [7:0] sboxModel(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    b = r;
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] subState(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sboxModel(s[127-8*i -: 8]);
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Job timeline: 16 edges after acceptance the result appears with done.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mLeft = 0;
      mOut  = '0;
      mDone = 1'b0;
    end else begin
      mDone = 1'b0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mOut  = mPending;
          mDone = 1'b1;
        end
      end else if (enableS) begin
        mPending = subState(blocoIn);
        mLeft    = 16;
      end
    end
    mBusy = (mLeft > 0);
  end

  always @(posedge clock) begin
    #3;
    chk("blocoOut", blocoOut, mOut);
    chk("busy", {127'd0, busy}, {127'd0, mBusy});
    chk("done", {127'd0, done}, {127'd0, mDone});
    if (done) doneCount++;
    if (busy) busyCycles++;
  end

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done not seen, got 0 expected 1", name);
    end
  endtask

  task automatic runJob(input logic [127:0] inB, input logic [127:0] expB,
                        input string name);
    @(negedge clock);
    blocoIn = inB;
    enableS = 1'b1;
    @(negedge clock);
    enableS = 1'b0;
    blocoIn = ~inB;
    waitDone(name);
    chk(name, blocoOut, expB);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int d0;
    logic [127:0] blk;

    chk("S(00)", {120'd0, sboxModel(8'h00)}, 128'h63);
    chk("S(01)", {120'd0, sboxModel(8'h01)}, 128'h7c);
    chk("S(53)", {120'd0, sboxModel(8'h53)}, 128'hed);
    chk("S(FF)", {120'd0, sboxModel(8'hff)}, 128'h16);

    repeat (3) @(negedge clock);
    chk("resetOut", blocoOut, 128'h0);
    chk("resetBusy", {127'd0, busy}, 128'h0);
    reset = 1'b1;
    @(negedge clock);

    busyCycles = 0;
    d0 = doneCount;
    runJob(128'h19a09ae93df4c6f8e3e28d48be2b2a08,
           128'hd4e0b81e27bfb44111985d52aef1e530, "fips1");
    chk("busyLen", busyCycles, 16);
    chk("doneOnce", doneCount - d0, 1);

    runJob(128'ha4686b029c9f5b6a7f35ea50f22b4349,
           128'h49457f77dedb3902d296875389f11a3b, "b2bA");
    runJob(128'haa6182688fddd2325fe34a4603efd29a,
           128'hacef134573c1b523cf11d65a7bdfb5b8, "b2bB");
    runJob(128'hf1c17c5d0092c8b56f4c8bd555ef320c,
           128'ha178104c634fe8d5a8293d03fcdf23fe, "boundary");
    runJob({16{8'hff}}, {16{8'h16}}, "allFF");

    // Mid-job input change and stray enable are ignored.
    d0 = doneCount;
    @(negedge clock);
    blocoIn = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    enableS = 1'b1;
    @(negedge clock);
    enableS = 1'b0;
    repeat (2) @(negedge clock);
    blocoIn = 128'h0123456789abcdef0123456789abcdef;
    repeat (2) @(negedge clock);
    enableS = 1'b1;
    @(negedge clock);
    enableS = 1'b0;
    repeat (25) @(negedge clock);
    chk("noRestart", blocoOut, 128'hd4e0b81e27bfb44111985d52aef1e530);
    chk("noRestartDone", doneCount - d0, 1);

    // Reset in the middle of a job aborts it.
    d0 = doneCount;
    @(negedge clock);
    blocoIn = 128'ha4686b029c9f5b6a7f35ea50f22b4349;
    enableS = 1'b1;
    @(negedge clock);
    enableS = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("abortOut", blocoOut, 128'h0);
    chk("abortBusy", {127'd0, busy}, 128'h0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("abortNoDone", doneCount - d0, 0);
    runJob(128'h5a19a37a4149e08c42dc190cb11f650c,
           128'hbed40ada833be1642c86d4fec8c04dfe, "afterReset");

    // Level-held enable: one job per idle edge.
    d0 = doneCount;
    @(negedge clock);
    blocoIn = 128'h00112233445566778899aabbccddeeff;
    enableS = 1'b1;
    repeat (40) @(negedge clock);
    enableS = 1'b0;
    repeat (20) @(negedge clock);
    chk("heldEnableJobs", doneCount - d0, 3);

    // Sweep all 256 S-box entries.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(16 * j + i);
      runJob(blk, subState(blk), "sweep");
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_bytes_lp.md
Name: sub_bytes_lp

Overview:
- Low-power AES SubBytes stage. Applies the AES S-box to all 16 bytes of a 128-bit state block.
- Uses a single shared S-box, iterated over 16 clock cycles, instead of 16 parallel S-boxes.
- Sits in the AES round datapath after AddRoundKey. Started by a one-cycle enable pulse from the round controller.

Parameters:
- None. Block width is fixed at 128 bits (16 bytes), and the S-box is the fixed AES forward S-box.

Ports:
- clock  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enableS  input  1  start request; sampled high on a rising edge while idle.
- blocoIn  input  128 [0:127]  input state; byte i = bits [8i : 8i+7], byte 0 = bits [0:7] (MSB-first numbering).
- blocoOut  output  128 [0:127]  substituted state, same byte ordering as blocoIn.
- busy  output  1  high while a substitution is in progress.
- done  output  1  one-cycle pulse when blocoOut has just been updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE; byte index is cleared.
  - Capture register and blocoOut clear to 128'h0.
  - busy=0, done=0.
  - Reset asserted mid-operation aborts the job; no partial result ever reaches blocoOut.
- State machine has two states: IDLE and RUN.
- IDLE:
  - On a rising edge with enableS=1 (edge E0), capture blocoIn into an internal 128-bit register, set index=0, go to RUN, busy=1.
  - enableS=0 leaves the state unchanged.
- RUN, on each rising edge Ek (k=1..16):
  - Byte (k-1) of the capture register passes through the single S-box; the result is written into byte (k-1) of a working result register.
  - Index then increments.
- Completion at edge E16:
  - The full working result is copied to blocoOut in one update; blocoOut never shows partial results.
  - done=1 for exactly the cycle following E16; busy=0 from E16.
  - State returns to IDLE.
- Latency: 16 clock cycles from the enable-sampling edge to the blocoOut update.
- Minimum spacing between accepted starts is 17 edges.
- Between jobs, blocoOut holds the previous result indefinitely.
- blocoIn is read only at E0. Changes afterwards do not affect the current job.
- enableS high during RUN is ignored: no restart, no queueing.
- enableS held high in IDLE on consecutive edges starts exactly one job per IDLE edge. A level held through completion starts a new job on the first IDLE edge.
- S-box:
  - Combinational 256-entry AES forward S-box (256-way case or ROM).
  - Shared by all bytes; index-driven 16:1 byte multiplexer on its input.
  - Examples: S(00)=63, S(01)=7c, S(53)=ed, S(FF)=16.
- Low-power requirements:
  - Capture and result registers load only when enabled.
  - The S-box input multiplexer is held at byte 0 in IDLE, so there is no toggling when idle.

Test Plan:
- Reset, then pulse enableS one cycle with blocoIn=19a09ae93df4c6f8e3e28d48be2b2a08 -> after 16 cycles blocoOut=d4e0b81e27bfb441 11985d52aef1e530; done pulses once; busy high for 16 cycles.
- Back-to-back jobs with 19-cycle spacing:
  - a4686b029c9f5b6a7f35ea50f22b4349 -> 49457f77dedb3902d296875389f11a3b
  - then aa6182688fddd2325fe34a4603efd29a -> acef134573c1b523cf11d65a7bdfb5b8
- Boundary bytes: f1c17c5d0092c8b56f4c8bd555ef320c -> a178104c634fe8d5a8293d03fcdf23fe (checks S(00)=63). All-FF input -> all-16 output.
- Pulse enableS again at cycle 5 of a job, and change blocoIn at cycle 3 -> result equals the S-box of the originally captured block; no restart; exactly one done pulse.
- Assert reset low at cycle 8 of a job -> blocoOut=0, busy=0, done never pulses. After release, a new enableS with 5a19a37a4149e08c42dc190cb11f650c -> bed40ada833be1642c86d4fec8c04dfe.
- Verify blocoOut is stable during RUN and equals the prior result until the update edge; compare all 256 S-box entries via 16 jobs against a reference model.
